hack_data_responder: RTL and testbench

- Data-memory-side responder for the Hack CPU data port (addressM/writeM/outM/inM).
- Decodes the Hack memory map:
  - RAM: 0x0000–0x3FFF
  - SCREEN: 0x4000–0x5FFF
  - KBD: 0x6000
- Returns read data combinationally in the same cycle.
- Buffers screen writes into a FIFO toward the display domain, and serves keyboard codes from an input FIFO that the CPU acknowledges by writing KBD.

---
 rtl/hack_data_responder_if.sv | 28 ++
 rtl/hack_data_responder.sv | 143 ++++++++++++++
 tb/tb_hack_data_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_data_responder_if.sv
// Hack CPU data-port bundle: CPU bus (addressM/writeM/outM/inM), keyboard code
// input handshake and screen-write output handshake.
//   master: CPU/keyboard/display side (drives addr, write_en, wdata, key_*, scr_ready)
//   slave : the data responder (drives rdata, key_ready, scr_*)
interface hack_data_responder_if;
    logic [14:0] addr;
    logic        write_en;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        key_valid;
    logic [15:0] key_code;
    logic        key_ready;
    logic        scr_valid;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_ready;
    logic        scr_overflow;

    modport master (
        output addr, write_en, wdata, key_valid, key_code, scr_ready,
        input  rdata, key_ready, scr_valid, scr_addr, scr_data, scr_overflow
    );

    modport slave (
        input  addr, write_en, wdata, key_valid, key_code, scr_ready,
        output rdata, key_ready, scr_valid, scr_addr, scr_data, scr_overflow
    );
endinterface

// File: rtl/hack_data_responder.sv
// Data-memory responder for the Hack CPU.
// Memory map: RAM 0x0000-0x3FFF, SCREEN 0x4000-0x5FFF, KBD 0x6000; rest reads 0.
// Reads are combinational from addr. Screen writes are queued in a FIFO toward the
// display; keyboard codes are queued in a FIFO and acknowledged by a CPU write to KBD.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; empties both FIFOs and clears scr_overflow
//   bus   - hack_data_responder_if.slave (CPU bus, keyboard input, screen output)
// Optional: define HACK_SCREEN_SHADOW_EN to add an 8192x16 screen shadow RAM that
// SCREEN-region reads return; otherwise SCREEN reads return 0.
module hack_data_responder #(
    parameter int unsigned RAM_AW    = 14,
    parameter int unsigned KEY_DEPTH = 4,
    parameter int unsigned SCR_DEPTH = 8
) (
    input logic                  clk,
    input logic                  reset,
    hack_data_responder_if.slave bus
);
    localparam int unsigned KPW      = $clog2(KEY_DEPTH);
    localparam int unsigned KCW      = KPW + 1;
    localparam int unsigned SPW      = $clog2(SCR_DEPTH);
    localparam int unsigned SCW      = SPW + 1;
    localparam int unsigned RamWords = 2 ** RAM_AW;

    logic [15:0]    ram_q [RamWords];
    logic [15:0]    key_mem_q [KEY_DEPTH];
    logic [28:0]    scr_mem_q [SCR_DEPTH];

    logic [KPW-1:0] key_wptr_q, key_wptr_d, key_rptr_q, key_rptr_d;
    logic [KCW-1:0] key_cnt_q, key_cnt_d;
    logic [SPW-1:0] scr_wptr_q, scr_wptr_d, scr_rptr_q, scr_rptr_d;
    logic [SCW-1:0] scr_cnt_q, scr_cnt_d;
    logic           scr_ovf_q, scr_ovf_d;

    logic ram_sel, scr_sel, kbd_sel;
    logic key_full, key_empty, key_push, key_pop;
    logic scr_full, scr_empty, scr_wr, scr_push, scr_pop;
    logic [28:0] scr_head;
    logic [15:0] rdata;

    assign ram_sel = ~bus.addr[14];
    assign scr_sel = (bus.addr[14:13] == 2'b10);
    assign kbd_sel = (bus.addr == 15'h6000);

    assign key_full  = (key_cnt_q == KCW'(KEY_DEPTH));
    assign key_empty = (key_cnt_q == '0);
    // Zero codes are handshaken but never enter the queue.
    assign key_push  = bus.key_valid && !key_full && (bus.key_code != 16'h0000);
    assign key_pop   = bus.write_en && kbd_sel && !key_empty;

    assign scr_full  = (scr_cnt_q == SCW'(SCR_DEPTH));
    assign scr_empty = (scr_cnt_q == '0);
    assign scr_wr    = bus.write_en && scr_sel;
    assign scr_pop   = !scr_empty && bus.scr_ready;
    // A same-cycle pop frees the slot the push lands in.
    assign scr_push  = scr_wr && (!scr_full || scr_pop);

    always_comb begin
        key_wptr_d = key_wptr_q;
        key_rptr_d = key_rptr_q;
        key_cnt_d  = key_cnt_q;
        if (key_push) key_wptr_d = key_wptr_q + KPW'(1);
        if (key_pop)  key_rptr_d = key_rptr_q + KPW'(1);
        case ({key_push, key_pop})
            2'b10:   key_cnt_d = key_cnt_q + KCW'(1);
            2'b01:   key_cnt_d = key_cnt_q - KCW'(1);
            default: key_cnt_d = key_cnt_q;
        endcase
    end

    always_comb begin
        scr_wptr_d = scr_wptr_q;
        scr_rptr_d = scr_rptr_q;
        scr_cnt_d  = scr_cnt_q;
        scr_ovf_d  = scr_ovf_q | (scr_wr && !scr_push);
        if (scr_push) scr_wptr_d = scr_wptr_q + SPW'(1);
        if (scr_pop)  scr_rptr_d = scr_rptr_q + SPW'(1);
        case ({scr_push, scr_pop})
            2'b10:   scr_cnt_d = scr_cnt_q + SCW'(1);
            2'b01:   scr_cnt_d = scr_cnt_q - SCW'(1);
            default: scr_cnt_d = scr_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_wptr_q <= '0;
            key_rptr_q <= '0;
            key_cnt_q  <= '0;
            scr_wptr_q <= '0;
            scr_rptr_q <= '0;
            scr_cnt_q  <= '0;
            scr_ovf_q  <= 1'b0;
        end else begin
            key_wptr_q <= key_wptr_d;
            key_rptr_q <= key_rptr_d;
            key_cnt_q  <= key_cnt_d;
            scr_wptr_q <= scr_wptr_d;
            scr_rptr_q <= scr_rptr_d;
            scr_cnt_q  <= scr_cnt_d;
            scr_ovf_q  <= scr_ovf_d;
        end
    end

    // Storage arrays are never reset; queued entries are discarded via the pointers.
    always_ff @(posedge clk) begin
        if (bus.write_en && ram_sel) ram_q[bus.addr[RAM_AW-1:0]] <= bus.wdata;
        if (key_push) key_mem_q[key_wptr_q] <= bus.key_code;
        if (scr_push) scr_mem_q[scr_wptr_q] <= {bus.addr[12:0], bus.wdata};
    end

`ifdef HACK_SCREEN_SHADOW_EN
    logic [15:0] shadow_q [8192];

    // Written on every screen write, even ones the FIFO drops.
    always_ff @(posedge clk) begin
        if (scr_wr) shadow_q[bus.addr[12:0]] <= bus.wdata;
    end
`endif

    always_comb begin
        rdata = 16'h0000;
        if (ram_sel) begin
            rdata = ram_q[bus.addr[RAM_AW-1:0]];
        end else if (kbd_sel) begin
            rdata = key_empty ? 16'h0000 : key_mem_q[key_rptr_q];
        end
`ifdef HACK_SCREEN_SHADOW_EN
        else if (scr_sel) begin
            rdata = shadow_q[bus.addr[12:0]];
        end
`endif
    end

    assign scr_head         = scr_mem_q[scr_rptr_q];
    assign bus.rdata        = rdata;
    assign bus.key_ready    = !key_full;
    assign bus.scr_valid    = !scr_empty;
    assign bus.scr_addr     = scr_head[28:16];
    assign bus.scr_data     = scr_head[15:0];
    assign bus.scr_overflow = scr_ovf_q;
endmodule

// File: tb/tb_hack_data_responder.sv
// Bench for hack_data_responder: a vector table for RAM/KBD reads plus hand sequences
// for keyboard-full, screen FIFO overflow, full-with-pop and reset mid-stream.
// Keyboard and screen traffic are tracked by expected-value queues.
module tb_hack_data_responder;
    localparam int unsigned KEY_DEPTH = 4;
    localparam int unsigned SCR_DEPTH = 8;

    logic clk;
    logic reset;

    hack_data_responder_if bus ();

    hack_data_responder dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int scr_pops = 0;

    logic [15:0] kq[$];
    logic [28:0] sq[$];
    logic        movf;

    typedef struct packed {
        logic [14:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic        kv;
        logic [15:0] kc;
        logic        chk;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [14:0] a, input logic we, input logic [15:0] wd,
                                input logic kv, input logic [15:0] kc, input logic c,
                                input logic [15:0] e);
        vec_t v;
        v.addr = a; v.we = we; v.wdata = wd; v.kv = kv; v.kc = kc; v.chk = c; v.exp_rd = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [14:0] a, input logic we, input logic [15:0] wd,
                         input logic kv, input logic [15:0] kc);
        bus.addr = a; bus.write_en = we; bus.wdata = wd; bus.key_valid = kv; bus.key_code = kc;
    endtask

    // Called mid-cycle with inputs stable: compare flags, then update the model queues.
    task automatic sb_sample();
        logic kacc;
        logic [28:0] e;
        chkb("key_ready", bus.key_ready, kq.size() < KEY_DEPTH);
        chkb("scr_valid", bus.scr_valid, sq.size() != 0);
        chkb("scr_overflow", bus.scr_overflow, movf);
        kacc = bus.key_valid && (kq.size() < KEY_DEPTH) && (bus.key_code != 16'h0000);
        if (bus.write_en && bus.addr == 15'h6000 && kq.size() != 0) begin
            chk("kbd_pop_head", bus.rdata, kq.pop_front());
        end
        if (kacc) kq.push_back(bus.key_code);
        if (sq.size() != 0 && bus.scr_ready) begin
            e = sq.pop_front();
            chk("scr_addr", {3'b000, bus.scr_addr}, {3'b000, e[28:16]});
            chk("scr_data", bus.scr_data, e[15:0]);
            scr_pops++;
        end
        if (bus.write_en && bus.addr[14:13] == 2'b10) begin
            if (sq.size() < SCR_DEPTH) sq.push_back({bus.addr[12:0], bus.wdata});
            else movf = 1'b1;
        end
    endtask

    task automatic finish_cycle();
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        finish_cycle();
    endtask

    task automatic probe(input logic [14:0] a);
        drive(a, 1'b0, 16'h0000, 1'b0, 16'h0000);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(15'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        kq.delete();
        sq.delete();
        movf = 1'b0;
    endtask

    initial begin
        logic [15:0] shadow_ffff;
        logic [15:0] shadow_dead;
`ifdef HACK_SCREEN_SHADOW_EN
        shadow_ffff = 16'hFFFF;
        shadow_dead = 16'hDEAD;
`else
        shadow_ffff = 16'h0000;
        shadow_dead = 16'h0000;
`endif
        movf = 1'b0;
        bus.scr_ready = 1'b0;
        drive(15'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Post-reset state
        probe(15'h6000);
        chk("rst_kbd", bus.rdata, 16'h0000);
        chkb("rst_key_ready", bus.key_ready, 1'b1);
        chkb("rst_scr_valid", bus.scr_valid, 1'b0);
        chkb("rst_overflow", bus.scr_overflow, 1'b0);
        finish_cycle();

        // rdata is checked before the edge, so it reflects state left by earlier rows.
        vecs.push_back(mk(15'h0005, 1, 16'h1234, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(15'h0005, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234));
        vecs.push_back(mk(15'h6001, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(15'h6000, 0, 16'h0000, 1, 16'h0041, 1, 16'h0000));
        vecs.push_back(mk(15'h6000, 0, 16'h0000, 1, 16'h0042, 1, 16'h0041));
        vecs.push_back(mk(15'h6000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0041));
        vecs.push_back(mk(15'h6000, 1, 16'h0000, 0, 16'h0000, 1, 16'h0041));
        vecs.push_back(mk(15'h6000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0042));
        vecs.push_back(mk(15'h6000, 1, 16'h9999, 0, 16'h0000, 1, 16'h0042));
        vecs.push_back(mk(15'h6000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(15'h6000, 1, 16'h0000, 0, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(15'h6000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(15'h6001, 1, 16'hBEEF, 0, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(15'h6001, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000));
        vecs.push_back(mk(15'h3FFF, 1, 16'h5555, 0, 16'h0000, 0, 16'h0000));
        vecs.push_back(mk(15'h3FFF, 0, 16'h0000, 0, 16'h0000, 1, 16'h5555));
        vecs.push_back(mk(15'h0005, 0, 16'h0000, 0, 16'h0000, 1, 16'h1234));
        vecs.push_back(mk(15'h6000, 1, 16'h0000, 1, 16'h0043, 1, 16'h0000));
        vecs.push_back(mk(15'h6000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0043));
        vecs.push_back(mk(15'h6000, 1, 16'h0000, 0, 16'h0000, 1, 16'h0043));
        vecs.push_back(mk(15'h6000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000));

        foreach (vecs[i]) begin
            drive(vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].kv, vecs[i].kc);
            @(negedge clk);
            if (vecs[i].chk) chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rd);
            finish_cycle();
        end

        // Keyboard: zero code dropped, fill to full, reject extra, pop-only when full
        drive(15'h6000, 0, 16'h0000, 1, 16'h0000); cycle();
        drive(15'h6000, 0, 16'h0000, 1, 16'h0011); cycle();
        drive(15'h6000, 0, 16'h0000, 1, 16'h0022); cycle();
        drive(15'h6000, 0, 16'h0000, 1, 16'h0033); cycle();
        probe(15'h6000);
        chkb("key_ready_at3", bus.key_ready, 1'b1);
        finish_cycle();
        drive(15'h6000, 0, 16'h0000, 1, 16'h0044); cycle();
        drive(15'h6000, 0, 16'h0000, 1, 16'h0055); cycle();
        drive(15'h6000, 1, 16'h0000, 1, 16'h0066); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(15'h6000, 1, 16'h0000, 0, 16'h0000); cycle();
        end
        probe(15'h6000);
        chk("kbd_after_drain", bus.rdata, 16'h0000);
        finish_cycle();

        // Screen FIFO fill and overflow with scr_ready low
        bus.scr_ready = 1'b0;
        drive(15'h4000, 1, 16'hFFFF, 0, 16'h0000); cycle();
        probe(15'h0005);
        chkb("scr_first_valid", bus.scr_valid, 1'b1);
        chk("scr_first_addr", {3'b000, bus.scr_addr}, 16'h0000);
        chk("scr_first_data", bus.scr_data, 16'hFFFF);
        finish_cycle();
        for (int i = 1; i < 8; i++) begin
            drive(15'(15'h4000 + i), 1, 16'(16'h1000 + i), 0, 16'h0000); cycle();
        end
        drive(15'h5FFF, 1, 16'hDEAD, 0, 16'h0000); cycle();
        probe(15'h0005);
        chkb("scr_overflow_set", bus.scr_overflow, 1'b1);
        finish_cycle();
        bus.scr_ready = 1'b1;
        repeat (10) cycle();
        probe(15'h0005);
        chkb("ovf_after_drain", bus.scr_overflow, 1'b1);
        chkb("valid_after_drain", bus.scr_valid, 1'b0);
        finish_cycle();
        probe(15'h5FFF);
        chk("shadow_dropped_write", bus.rdata, shadow_dead);
        finish_cycle();
        probe(15'h4000);
        chk("shadow_4000", bus.rdata, shadow_ffff);
        finish_cycle();

        // Full FIFO with simultaneous pop and push
        do_reset();
        bus.scr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(15'(15'h4200 + i), 1, 16'(16'h2000 + i), 0, 16'h0000); cycle();
        end
        bus.scr_ready = 1'b1;
        drive(15'h4100, 1, 16'hA5A5, 0, 16'h0000); cycle();
        probe(15'h0005);
        chkb("full_pop_no_ovf", bus.scr_overflow, 1'b0);
        scr_pops = 0;
        finish_cycle();
        drive(15'h0005, 0, 16'h0000, 0, 16'h0000);
        repeat (10) cycle();
        chk("full_pop_count", 16'(scr_pops), 16'd8);

        // Reset mid-stream
        bus.scr_ready = 1'b0;
        drive(15'h4000, 1, 16'hFFFF, 1, 16'h0071); cycle();
        for (int i = 1; i < 5; i++) begin
            drive(15'(15'h4000 + i), 1, 16'(16'h3000 + i), i < 3, 16'(16'h0071 + i)); cycle();
        end
        do_reset();
        probe(15'h6000);
        chk("mid_rst_kbd", bus.rdata, 16'h0000);
        chkb("mid_rst_key_ready", bus.key_ready, 1'b1);
        chkb("mid_rst_scr_valid", bus.scr_valid, 1'b0);
        chkb("mid_rst_overflow", bus.scr_overflow, 1'b0);
        finish_cycle();
        probe(15'h0005);
        chk("ram_retained", bus.rdata, 16'h1234);
        finish_cycle();
        probe(15'h4000);
        chk("shadow_retained", bus.rdata, shadow_ffff);
        finish_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
